// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the req/ack handshake to
// instruction memory and holds one fetched instruction for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign target  = {redirect_pc[31:2], 2'b00};
    assign pc_next = pc + 32'd4;

    // imem_req/imem_addr are registered; imem_addr only moves off an
    // outstanding request once that request has been acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= 32'd0;
            if_instr  <= 32'd0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= target;
                        imem_addr <= target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            discard   <= 1'b0;
                            imem_addr <= target;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (discard) begin
                            // pc already holds the latest redirect target
                            discard   <= 1'b0;
                            imem_addr <= pc;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_instr <= imem_rdata;
                            pc       <= pc_next;
                            state    <= FULL;
                            imem_req <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (redirect) begin
                        pc        <= target;
                        if_valid  <= 1'b0;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= target;
                    end else if (if_ready) begin
                        if_valid  <= 1'b0;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
